// File: rtl/dp_trace_if.sv
// dp_trace_if: capture/trigger/readout bundle for dp_trace_buf (master = driver side, slave = trace buffer)
interface dp_trace_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
);
  logic                   arm;
  logic                   trig_en;
  logic [XLEN-1:0]        trig_pc;
  logic                   cap_valid;
  logic [XLEN-1:0]        cap_pc;
  logic [31:0]            cap_inst;
  logic [XLEN-1:0]        cap_wb_data;
  logic                   rd_req;
  logic                   rd_valid;
  logic [XLEN-1:0]        rd_pc;
  logic [31:0]            rd_inst;
  logic [XLEN-1:0]        rd_wb_data;
  logic [$clog2(DEPTH):0] count;
  logic [1:0]             state;
  logic                   triggered;
  modport master (
    output arm, trig_en, trig_pc, cap_valid, cap_pc, cap_inst, cap_wb_data, rd_req,
    input  rd_valid, rd_pc, rd_inst, rd_wb_data, count, state, triggered
  );
  modport slave (
    input  arm, trig_en, trig_pc, cap_valid, cap_pc, cap_inst, cap_wb_data, rd_req,
    output rd_valid, rd_pc, rd_inst, rd_wb_data, count, state, triggered
  );
endinterface

// File: rtl/dp_trace_buf.sv
// dp_trace_buf: retire-trace circular buffer with PC trigger, post-trigger capture and freeze-then-read; DP_TRACE_WB_EN stores write-back data
module dp_trace_buf #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 16,
  parameter int POST_CNT = 4
) (
  input logic     clk,
  input logic     rst,
  dp_trace_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, RUN, POST, FROZEN} state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d;
  logic [CW-1:0]   count_q, count_d;
  logic            triggered_q, triggered_d, rd_valid_q, rd_valid_d;
  logic [XLEN-1:0] rd_pc_q, rd_pc_d;
  logic [31:0]     rd_inst_q, rd_inst_d;
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic            capture, match, full, pop;
  always_comb begin
    capture     = !bus.arm && bus.cap_valid && (state_q == RUN || state_q == POST);
    match       = state_q == RUN && bus.trig_en && bus.cap_pc == bus.trig_pc;
    full        = count_q == CW'(DEPTH);
    pop         = !bus.arm && bus.rd_req && state_q == FROZEN && count_q != '0;
    wr_ptr_d    = bus.arm ? '0 : wr_ptr_q + AW'(capture);
    rd_ptr_d    = bus.arm ? '0 : rd_ptr_q + AW'(pop || (capture && full));
    count_d     = bus.arm ? '0 : pop ? count_q - CW'(1) : count_q + CW'(capture && !full);
    post_d      = bus.arm ? '0 : (capture && match) ? AW'(POST_CNT) :
                  (capture && state_q == POST) ? post_q - AW'(1) : post_q;
    triggered_d = !bus.arm && (triggered_q || (capture && match));
    state_d     = bus.arm ? RUN : (capture && match) ? (POST_CNT == 0 ? FROZEN : POST) :
                  (capture && state_q == POST && post_q == AW'(1)) ? FROZEN : state_q;
    rd_valid_d  = pop;
    rd_pc_d     = pop ? pc_mem[rd_ptr_q] : rd_pc_q;
    rd_inst_d   = pop ? inst_mem[rd_ptr_q] : rd_inst_q;
  end
  always_ff @(posedge clk) begin
    if (capture) begin
      pc_mem[wr_ptr_q]   <= bus.cap_pc;
      inst_mem[wr_ptr_q] <= bus.cap_inst;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      post_q      <= '0;
      count_q     <= '0;
      triggered_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_pc_q     <= '0;
      rd_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      post_q      <= post_d;
      count_q     <= count_d;
      triggered_q <= triggered_d;
      rd_valid_q  <= rd_valid_d;
      rd_pc_q     <= rd_pc_d;
      rd_inst_q   <= rd_inst_d;
    end
  end
`ifdef DP_TRACE_WB_EN
  logic [XLEN-1:0] wb_mem [DEPTH];
  logic [XLEN-1:0] rd_wb_q, rd_wb_d;
  always_comb rd_wb_d = pop ? wb_mem[rd_ptr_q] : rd_wb_q;
  always_ff @(posedge clk) begin
    if (capture) wb_mem[wr_ptr_q] <= bus.cap_wb_data;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_wb_q <= '0;
    else rd_wb_q <= rd_wb_d;
  end
  assign bus.rd_wb_data = rd_wb_q;
`else
  logic unused_wb;
  assign unused_wb      = ^bus.cap_wb_data;
  assign bus.rd_wb_data = '0;
`endif
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_pc     = rd_pc_q;
  assign bus.rd_inst   = rd_inst_q;
  assign bus.count     = count_q;
  assign bus.state     = state_q;
  assign bus.triggered = triggered_q;
endmodule

// File: tb/tb_dp_trace_buf.sv
// tb_dp_trace_buf: directed scoreboard bench for dp_trace_buf (u0 POST_CNT=4, u1 POST_CNT=0, shared stimulus)
module tb_dp_trace_buf;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam logic [31:0] WB = 32'hDEADBEEF;
`ifdef DP_TRACE_WB_EN
  localparam bit WB_ON = 1'b1;
`else
  localparam bit WB_ON = 1'b0;
`endif
  typedef struct {logic [31:0] pc; logic [31:0] inst; logic [31:0] wb;} ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0, trig_en = 1'b0, cap_valid = 1'b0, rd_req = 1'b0;
  logic [31:0] trig_pc = '0, cap_pc = '0, cap_inst = '0, cap_wb = '0;
  ent_t q0[$], q1[$];
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  dp_trace_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus0 ();
  dp_trace_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus1 ();
  assign bus0.arm = arm;         assign bus1.arm = arm;
  assign bus0.trig_en = trig_en; assign bus1.trig_en = trig_en;
  assign bus0.trig_pc = trig_pc; assign bus1.trig_pc = trig_pc;
  assign bus0.cap_valid = cap_valid; assign bus1.cap_valid = cap_valid;
  assign bus0.cap_pc = cap_pc;   assign bus1.cap_pc = cap_pc;
  assign bus0.cap_inst = cap_inst; assign bus1.cap_inst = cap_inst;
  assign bus0.cap_wb_data = cap_wb; assign bus1.cap_wb_data = cap_wb;
  assign bus0.rd_req = rd_req;   assign bus1.rd_req = rd_req;
  dp_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_CNT(4)) u0 (.clk(clk), .rst(rst), .bus(bus0));
  dp_trace_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .POST_CNT(0)) u1 (.clk(clk), .rst(rst), .bus(bus1));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cap(input logic [31:0] pc, input bit p0, input bit p1);
    ent_t e;
    e = '{pc, pc ^ 32'h00A5_0013, WB_ON ? WB : 32'h0};
    @(negedge clk);
    cap_valid = 1'b1; cap_pc = pc; cap_inst = pc ^ 32'h00A5_0013; cap_wb = WB;
    @(posedge clk); #1;
    cap_valid = 1'b0;
    if (p0) begin
      if (q0.size() == DEPTH) q0.delete(0);
      q0.push_back(e);
    end
    if (p1) begin
      if (q1.size() == DEPTH) q1.delete(0);
      q1.push_back(e);
    end
  endtask
  task automatic arm_pulse(input bit with_rd);
    @(negedge clk);
    arm = 1'b1; rd_req = with_rd;
    @(posedge clk); #1;
    arm = 1'b0; rd_req = 1'b0;
    q0.delete(); q1.delete();
  endtask
  task automatic chk_pop(input bit sel, input string tag);
    ent_t e;
    chk({tag, "_valid"}, sel ? bus1.rd_valid : bus0.rd_valid, 1);
    if ((sel ? q1.size() : q0.size()) == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sel ? q1.pop_front() : q0.pop_front();
      chk({tag, "_pc"}, sel ? bus1.rd_pc : bus0.rd_pc, e.pc);
      chk({tag, "_inst"}, sel ? bus1.rd_inst : bus0.rd_inst, e.inst);
      chk({tag, "_wb"}, sel ? bus1.rd_wb_data : bus0.rd_wb_data, e.wb);
    end
  endtask
  task automatic rd_burst(input bit sel, input int n_cyc, input int n_valid, input string tag);
    @(negedge clk);
    rd_req = 1'b1;
    for (int i = 0; i < n_cyc; i++) begin
      @(posedge clk); #1;
      if (i < n_valid) chk_pop(sel, tag);
      else chk({tag, "_idle"}, sel ? bus1.rd_valid : bus0.rd_valid, 0);
    end
    rd_req = 1'b0;
  endtask
  initial begin
    #1 rst = 1'b0;
    #3;
    chk("rst_state", bus0.state, 0);
    chk("rst_count", bus0.count, 0);
    chk("rst_trig", bus0.triggered, 0);
    chk("rst_rdv", bus0.rd_valid, 0);
    chk("rst_rdpc", bus0.rd_pc, 0);
    @(negedge clk); rst = 1'b1;
    cap(32'h40, 0, 0);
    chk("idle_nocap_count", bus0.count, 0);
    chk("idle_state", bus0.state, 0);
    // basic capture, trigger, post window, freeze, readout
    arm_pulse(0);
    chk("arm_state", bus0.state, 1);
    for (int i = 0; i < 3; i++) cap(32'(i * 4), 1, 1);
    chk("run_count3", bus0.count, 3);
    trig_en = 1'b1; trig_pc = 32'hC;
    cap(32'hC, 1, 1);
    chk("post_state", bus0.state, 2);
    chk("post_trig", bus0.triggered, 1);
    for (int i = 0; i < 4; i++) cap(32'h10 + 32'(i * 4), 1, 0);
    chk("frozen_state", bus0.state, 3);
    chk("frozen_count8", bus0.count, 8);
    cap(32'h100, 0, 0);
    chk("frozen_nocap", bus0.count, 8);
    rd_burst(0, 6, 6, "rd035");
    chk("rd035_count2", bus0.count, 2);
    rd_burst(0, 4, 2, "rd037");
    chk("rd037_count0", bus0.count, 0);
    chk("rd037_hold_pc", bus0.rd_pc, 32'h1C);
    chk("rd037_hold_rdv", bus0.rd_valid, 0);
    // arm with same-cycle rd_req while frozen
    arm_pulse(0);
    trig_pc = 32'h200;
    for (int i = 0; i < 5; i++) cap(32'h200 + 32'(i * 4), 1, 0);
    chk("f5_state", bus0.state, 3);
    chk("f5_count", bus0.count, 5);
    arm_pulse(1);
    chk("arm_rd_rdv", bus0.rd_valid, 0);
    chk("arm_rd_count", bus0.count, 0);
    chk("arm_rd_state", bus0.state, 1);
    chk("arm_rd_trig", bus0.triggered, 0);
    // wrap with free-running trace, then immediate freeze on u1
    trig_en = 1'b0;
    for (int i = 0; i < 20; i++) cap(32'(i * 4), 1, 1);
    chk("wrap_count16", bus1.count, 16);
    chk("wrap_state_run", bus1.state, 1);
    trig_en = 1'b1; trig_pc = 32'h50;
    cap(32'h50, 1, 1);
    chk("u1_frozen", bus1.state, 3);
    chk("u1_count16", bus1.count, 16);
    chk("u1_trig", bus1.triggered, 1);
    chk("u0_post", bus0.state, 2);
    rd_burst(1, 1, 1, "rd036a");
    chk("rd036_first", bus1.rd_pc, 32'h14);
    rd_burst(1, 15, 15, "rd036b");
    chk("rd036_last", bus1.rd_pc, 32'h50);
    chk("rd036_count0", bus1.count, 0);
    // async reset during post window
    arm_pulse(0);
    trig_pc = 32'h18;
    for (int i = 0; i < 7; i++) cap(32'(i * 4), 1, 0);
    chk("p7_state", bus0.state, 2);
    chk("p7_count", bus0.count, 7);
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    chk("arst_state", bus0.state, 0);
    chk("arst_count", bus0.count, 0);
    chk("arst_trig", bus0.triggered, 0);
    @(negedge clk); rst = 1'b1;
    rd_burst(0, 2, 0, "arst_rd");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dp_trace_buf.md
DP_TRACE_BUF -- requirements
Module: dp_trace_buf

Interface
REQ-001 Parameter XLEN, default 32, datapath word width of PC, instruction and write-back fields.
REQ-002 Parameter DEPTH, default 16, trace entries; power of two, minimum 4.
REQ-003 Parameter POST_CNT, default 4, entries captured after trigger before freezing; range 0..DEPTH-1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 arm  input  1  one-cycle pulse; clears buffer and starts capture.
REQ-007 trig_en  input  1  enables PC-match trigger.
REQ-008 trig_pc  input  XLEN  trigger PC value.
REQ-009 cap_valid  input  1  one instruction retired this cycle.
REQ-010 cap_pc  input  XLEN  PC of retiring instruction.
REQ-011 cap_inst  input  32  retiring instruction word.
REQ-012 cap_wb_data  input  XLEN  register write-back data.
REQ-013 rd_req  input  1  request oldest entry.
REQ-014 rd_valid  output  1  rd_pc/rd_inst/rd_wb_data hold a popped entry this cycle.
REQ-015 rd_pc  output  XLEN; rd_inst  output  32; rd_wb_data  output  XLEN: popped entry fields.
REQ-016 count  output  clog2(DEPTH)+1  valid entries held.
REQ-017 state  output  2  IDLE=0, RUN=1, POST=2, FROZEN=3.
REQ-018 triggered  output  1  sticky; trigger matched since last arm.

Function
REQ-019 IDLE: no capture, no readout; arm -> RUN.
REQ-020 RUN: each cap_valid cycle writes {cap_pc, cap_inst, cap_wb_data} at write pointer, pointer increments modulo DEPTH.
REQ-021 RUN with count==DEPTH and cap_valid: oldest entry overwritten, read pointer advances, count stays DEPTH.
REQ-022 RUN, cap_valid, trig_en, cap_pc==trig_pc: matching entry captured, triggered set, post counter loaded with POST_CNT; next state POST, or FROZEN when POST_CNT==0.
REQ-023 POST: each cap_valid captures one entry (wrap rules of REQ-021) and decrements post counter; capture that brings it to 0 -> FROZEN; further PC matches ignored.
REQ-024 FROZEN: no capture; rd_req with count>0 -> next cycle rd_valid=1 for one cycle with oldest entry, read pointer +1 mod DEPTH, count -1.
REQ-025 rd_req with count==0, or in any state other than FROZEN: ignored, rd_valid stays 0.
REQ-026 Read latency exactly one cycle; back-to-back rd_req returns consecutive entries every cycle.
REQ-027 arm in any state: pointers and count cleared, triggered cleared, state RUN next cycle; arm overrides same-cycle cap_valid and rd_req (neither takes effect).
REQ-028 rd_pc/rd_inst/rd_wb_data hold last popped value when rd_valid=0.
REQ-029 trig_en deasserted: RUN captures indefinitely (free-running circular trace).

Reset
REQ-030 rst low asynchronously forces: state IDLE, count 0, pointers 0, post counter 0, triggered 0, rd_valid 0, rd_pc/rd_inst/rd_wb_data 0.
REQ-031 Reset mid-capture or mid-readout discards all entries; storage array contents need not be cleared.
REQ-032 First capture possible on the edge after rst deasserts and arm is pulsed.

Configuration
REQ-033 Macro DP_TRACE_WB_EN defined: write-back field stored per entry and driven on rd_wb_data.
REQ-034 Macro DP_TRACE_WB_EN undefined: write-back storage omitted, cap_wb_data ignored, rd_wb_data tied to 0; all other behaviour identical.

Verification
REQ-035 Reset, arm, 3 captures PC 0x0,0x4,0x8, trig_en=0; trig via trig_en=1 trig_pc=0xC POST_CNT=4, captures to 0x1C -> FROZEN, count=8, reads return 0x0..0x1C in order.
REQ-036 DEPTH=16, trig_en=0, 20 captures PC 0x0..0x4C, then trig_pc=0x50 match, POST_CNT=0 -> FROZEN, count=16, first read PC 0x14, last 0x50.
REQ-037 FROZEN count=2, rd_req held 4 cycles -> rd_valid high exactly 2 cycles, count 0, outputs hold second entry.
REQ-038 arm and rd_req same cycle in FROZEN count=5 -> no rd_valid, count 0, state RUN, triggered 0.
REQ-039 rst low during POST with count=7 -> immediately state IDLE, count 0, triggered 0; rd_req afterwards -> no rd_valid.
REQ-040 Build without DP_TRACE_WB_EN, capture cap_wb_data=0xDEADBEEF -> read returns rd_wb_data=0, correct PC and instruction.
